// File: rtl/bp_resolve_queue.sv
// Branch resolution queue. It captures the predictor packet and final prediction for each
// branch at dispatch and holds them in program order. On execute-stage resolution it hands the
// packet back to the branch predictor together with the actual direction and mispredict flag.
// A mispredicted branch squashes every entry younger than itself.
// Optional feature: define BP_RESOLVE_STATS_EN to add saturating resolve/mispredict counters.
// `N (lane count) and `BP_PKT_W (packet width) default to 2 and 32 when not defined.

`ifndef N
`define N 2
`endif
`ifndef BP_PKT_W
`define BP_PKT_W 32
`endif

module bp_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = $clog2(DEPTH),
    parameter int unsigned PKT_W = `BP_PKT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [`N-1:0]           alloc_valid,
    input  logic [`N*PKT_W-1:0]     alloc_packets,
    input  logic [`N-1:0]           alloc_pred_taken,
    output logic                    alloc_ready,
    output logic [`N*TAG_W-1:0]     alloc_tags,
    input  logic                    ex_valid,
    input  logic [TAG_W-1:0]        ex_tag,
    input  logic                    ex_taken,
    input  logic                    flush,
    output logic                    resolving_valid_branch,
    output logic [PKT_W-1:0]        bs_bp_packet,
    output logic                    taken,
    output logic                    mispred,
`ifdef BP_RESOLVE_STATS_EN
    output logic [31:0]             stat_resolved,
    output logic [31:0]             stat_mispred,
`endif
    output logic [TAG_W:0]          free_count
);

    localparam int unsigned NL = `N;
    localparam logic [TAG_W:0] DepthW = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] LanesW = (TAG_W+1)'(NL);
    localparam logic [TAG_W:0] OneW   = (TAG_W+1)'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] resolved_q, resolved_d;
    logic [DEPTH-1:0] pred_q, pred_d;
    logic [PKT_W-1:0] pkt_q [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             rvb_q;
    logic [PKT_W-1:0] out_pkt_q;
    logic             taken_q;
    logic             mispred_q;

    logic [TAG_W:0]   alloc_k;
    logic             res_ok;
    logic             res_mis;
    logic             squash;
    logic             retire;
    logic             alloc_ok;
    logic [TAG_W-1:0] ex_off;
    logic [TAG_W:0]   squashed;
    logic [NL-1:0]    pkt_we;

    // Status outputs depend on registered state only.
    always_comb begin
        alloc_ready = (count_q <= (DepthW - LanesW));
        free_count  = DepthW - count_q;
        alloc_tags  = '0;
        for (int i = 0; i < NL; i++) begin
            alloc_tags[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
        end
    end

    // Decode this cycle's resolve / squash / retire / allocate events.
    always_comb begin
        alloc_k = '0;
        for (int i = 0; i < NL; i++) begin
            alloc_k = alloc_k + {{TAG_W{1'b0}}, alloc_valid[i]};
        end
        // A tag allocated this cycle is not yet valid in state, so it cannot resolve.
        res_ok   = ex_valid && valid_q[ex_tag] && !resolved_q[ex_tag] && !flush;
        res_mis  = (ex_taken != pred_q[ex_tag]);
        squash   = res_ok && res_mis;
        retire   = valid_q[head_q] && resolved_q[head_q];
        ex_off   = ex_tag - head_q;
        squashed = count_q - {1'b0, ex_off} - OneW;
        alloc_ok = alloc_ready && !squash && !flush && (alloc_k != '0);
        for (int i = 0; i < NL; i++) begin
            pkt_we[i] = alloc_ok && alloc_valid[i];
        end
    end

    // Next-state for entry flags and pointers; flush overrides everything else.
    always_comb begin
        logic [TAG_W-1:0] off;
        logic [TAG_W-1:0] idx;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        pred_d     = pred_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        off        = '0;
        idx        = '0;

        if (retire) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = head_q + TAG_W'(1);
        end
        if (res_ok) begin
            resolved_d[ex_tag] = 1'b1;
        end
        if (squash) begin
            // Entries further from head than the mispredicted branch are younger.
            for (int j = 0; j < DEPTH; j++) begin
                off = TAG_W'(j) - head_q;
                if (off > ex_off) begin
                    valid_d[j]    = 1'b0;
                    resolved_d[j] = 1'b0;
                end
            end
            tail_d = ex_tag + TAG_W'(1);
        end
        if (alloc_ok) begin
            for (int i = 0; i < NL; i++) begin
                if (alloc_valid[i]) begin
                    idx             = tail_q + TAG_W'(i);
                    valid_d[idx]    = 1'b1;
                    resolved_d[idx] = 1'b0;
                    pred_d[idx]     = alloc_pred_taken[i];
                end
            end
            tail_d = tail_q + alloc_k[TAG_W-1:0];
        end

        count_d = count_q
                + (alloc_ok ? alloc_k : '0)
                - {{TAG_W{1'b0}}, retire}
                - (squash ? squashed : '0);

        if (flush) begin
            valid_d    = '0;
            resolved_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    // Queue state registers and packet storage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q    <= '0;
            resolved_q <= '0;
            pred_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                pkt_q[j] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            pred_q     <= pred_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            for (int i = 0; i < NL; i++) begin
                if (pkt_we[i]) begin
                    pkt_q[tail_q + TAG_W'(i)] <= alloc_packets[i*PKT_W +: PKT_W];
                end
            end
        end
    end

    // Registered resolution interface to the predictor; data holds between strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rvb_q     <= 1'b0;
            out_pkt_q <= '0;
            taken_q   <= 1'b0;
            mispred_q <= 1'b0;
        end else begin
            rvb_q <= res_ok;
            if (res_ok) begin
                out_pkt_q <= pkt_q[ex_tag];
                taken_q   <= ex_taken;
                mispred_q <= res_mis;
            end
        end
    end

    assign resolving_valid_branch = rvb_q;
    assign bs_bp_packet           = out_pkt_q;
    assign taken                  = taken_q;
    assign mispred                = mispred_q;

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] stat_res_q;
    logic [31:0] stat_mis_q;

    // Saturating event counters, aligned with the outgoing strobe; flush leaves them alone.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res_ok && (stat_res_q != 32'hFFFF_FFFF)) begin
                stat_res_q <= stat_res_q + 32'd1;
            end
            if (squash && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign stat_resolved = stat_res_q;
    assign stat_mispred  = stat_mis_q;
`endif

endmodule
